cal_counter: RTL

CAL_COUNTER -- requirements
Module: cal_counter

---
 rtl/cal_pkg.sv | 27 ++
 rtl/cal_counter.sv | 107 ++++++++++
 2 files changed

// File: rtl/cal_pkg.sv
// Shared calendar constants for the calendar counter family.
// Includes the month-length table and a lookup helper.
package cal_pkg;

  localparam int DAYS_PER_WEEK = 7;
  localparam int MONTHS        = 12;
  localparam int HOURS         = 24;
  localparam int MINUTES       = 60;
  localparam int DOW_MIN       = 1;

  // Index 0 is January; February is the non-leap length, leap handling belongs to the parent.
  localparam logic [11:0][4:0] MONTH_DAYS = {
    5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31,
    5'd30, 5'd31, 5'd30, 5'd31, 5'd28, 5'd31
  };

  function automatic logic [4:0] month_days(input logic [3:0] month_idx);
    logic [4:0] days;
    if (month_idx < 4'd12) begin
      days = MONTH_DAYS[month_idx];
    end else begin
      days = 5'd31;
    end
    return days;
  endfunction

endpackage

// File: rtl/cal_counter.sv
// Cascadable calendar field counter (MIN_VAL..EMAX) with load, range check and carry chaining.
// Optional feature: define CAL_COUNTER_DOWN_EN to add the `down` port for borrow counting.
module cal_counter
  import cal_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 7,
  parameter int USE_LIMIT = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] limit,
  input  logic             enable,
`ifdef CAL_COUNTER_DOWN_EN
  input  logic             down,
`endif
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] databus,
  output logic             carry_out,
  output logic             at_max,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  if ((MAX_VAL > ((1 << WIDTH) - 1)) || (MIN_VAL > MAX_VAL) || (MIN_VAL < 0)) begin : g_param_check
    $error("cal_counter: require 0 <= MIN_VAL <= MAX_VAL <= 2**WIDTH-1");
  end

  logic [WIDTH-1:0] value_q, value_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] emax_s;
  logic             down_s;
  logic             wrap_s;
  logic             load_ok_s;

`ifdef CAL_COUNTER_DOWN_EN
  assign down_s = down;
`else
  assign down_s = 1'b0;
`endif

  // Effective top of range; a run-time limit is clamped into the static range.
  always_comb begin
    emax_s = MAX_W;
    if (USE_LIMIT != 0) begin
      if (limit < MIN_W) begin
        emax_s = MIN_W;
      end else if (limit > MAX_W) begin
        emax_s = MAX_W;
      end else begin
        emax_s = limit;
      end
    end else begin
      emax_s = MAX_W;
    end
  end

  // ">=" rather than "==" so a limit that drops below the held value still wraps next time.
  assign wrap_s    = down_s ? (value_q <= MIN_W) : (value_q >= emax_s);
  assign load_ok_s = (data >= MIN_W) && (data <= emax_s);

  always_comb begin
    value_d    = value_q;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        value_d = data;
      end else begin
        value_d    = MIN_W;
        load_err_d = 1'b1;
      end
    end else if (carry_in) begin
      if (wrap_s) begin
        value_d = down_s ? emax_s : MIN_W;
      end else begin
        value_d = down_s ? (value_q - ONE_W) : (value_q + ONE_W);
      end
    end else begin
      value_d = value_q;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      value_q    <= MIN_W;
      load_err_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      load_err_q <= load_err_d;
    end
  end

  // Carry is suppressed while clear is active so an abandoned wrap never propagates.
  assign carry_out = ~clear & carry_in & ~load & wrap_s;
  assign at_max    = (value_q >= emax_s);
  assign databus   = value_q & {WIDTH{enable}};
  assign value     = value_q;
  assign load_err  = load_err_q;

endmodule
